mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store unit between a CPU and a word-wide, little-endian data memory.
// Sub-word stores are done as read-modify-write; illegal accesses are rejected early.
module mem_access_ctrl #(
   parameter int ADDR_W    = 14,
   parameter int MEM_BYTES = 12288
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   input  logic [31:0]       dm_dout
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4,
      ERR    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic                sext_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic [31:0]         din_q;
   logic                acc_err_s;

   function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
      logic [31:0] base;
      base = 32'(a) & 32'hFFFF_FFFC;
      return (base + 32'd3) >= 32'(MEM_BYTES);
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = sx ? {{24{b[7]}}, b} : {24'd0, b};
         2'b01:   r = sx ? {{16{h[15]}}, h} : {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] off, input logic [1:0] sz);
      logic [31:0] r;
      r = word;
      case (sz)
         2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
         2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   // Reject misaligned, illegal-size and out-of-memory requests before any memory access.
   always_comb begin
      acc_err_s = 1'b0;
      if (size == 2'b11) begin
         acc_err_s = 1'b1;
      end else if ((size == 2'b01) && addr[0]) begin
         acc_err_s = 1'b1;
      end else if ((size == 2'b10) && (addr[1:0] != 2'b00)) begin
         acc_err_s = 1'b1;
      end else begin
         acc_err_s = out_of_range(addr);
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!req) begin
               state_d = IDLE;
            end else if (acc_err_s) begin
               state_d = ERR;
            end else if (!wr) begin
               state_d = LOAD;
            end else if (size == 2'b10) begin
               state_d = WRITE;
            end else begin
               state_d = RMW_RD;
            end
         end
         LOAD:    state_d = RESP;
         RMW_RD:  state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture, load result and store word; dm_din is loaded with wdata so word stores skip RMW.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         din_q   <= 32'd0;
      end else begin
         if ((state_q == IDLE) && req) begin
            addr_q  <= addr;
            size_q  <= size;
            sext_q  <= sign_ext;
            wdata_q <= wdata;
            if (wr) begin
               din_q <= wdata;
            end
         end
         if (state_q == LOAD) begin
            rdata_q <= load_extend(dm_dout, addr_q[1:0], size_q, sext_q);
         end
         if (state_q == RMW_RD) begin
            din_q <= store_merge(dm_dout, wdata_q, addr_q[1:0], size_q);
         end
      end
   end

   assign ready   = (state_q == RESP) || (state_q == ERR);
   assign err     = (state_q == ERR);
   assign busy    = (state_q != IDLE);
   assign dm_we   = (state_q == WRITE);
   assign dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign dm_din  = din_q;
   assign rdata   = rdata_q;

endmodule
